count_down_sequencer: RTL and testbench

- Control block for the 4-bit down-counter datapath (CLOCK/RESET/out counter used on the LED board).
- Owns the prescaler timebase and drives the counter's load and enable strobes.
- Sequences one countdown from a programmed start value: start, pause/resume, abort, terminal-count handling.
- Sits between the board keys/switches and the counter; the counter output feeds LEDs and returns here as cnt_val.

---
 rtl/count_down_sequencer_if.sv | 28 ++
 rtl/count_down_sequencer.sv | 155 +++++++++++++++
 tb/tb_count_down_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/count_down_sequencer_if.sv
// count_down_sequencer_if: keys/switches, counter strobes and status between
// the countdown sequencer and its surroundings. The sequencer is the slave
// side; whoever drives the keys and hosts the counter datapath is the master.
interface count_down_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_en;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    modport master (
        output start, pause, abort, load_val, cnt_val,
        input  cnt_load, cnt_load_val, cnt_en, busy, done, state
    );

    modport slave (
        input  start, pause, abort, load_val, cnt_val,
        output cnt_load, cnt_load_val, cnt_en, busy, done, state
    );
endinterface

// File: rtl/count_down_sequencer.sv
// count_down_sequencer: control block for the LED-board down-counter.
// Owns the prescaler timebase and issues one-cycle load/decrement strobes
// while sequencing a countdown (start, pause/resume, abort, terminal count).
// Optional macro COUNT_DOWN_DONE_BLINK_EN: in DONE the prescaler keeps
// running and done blinks, toggling on every tick; without it done is a
// steady 1 and the prescaler sits at 0.
module count_down_sequencer #(
    parameter int WIDTH        = 4,
    parameter int PRESCALE_DIV = 25000000,
    parameter int AUTO_RELOAD  = 0
) (
    input logic                   CLOCK,
    input logic                   RESET,
    count_down_sequencer_if.slave bus
);
    localparam int PW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_n;
    logic [PW-1:0]    presc_q, presc_n;
    logic             load_q, load_n;
    logic             en_q, en_n;
    logic [WIDTH-1:0] load_val_q, load_val_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             pause_q;
    logic             pause_rise;
    logic             tick;

    assign pause_rise = bus.pause & ~pause_q;
    assign tick       = (presc_q == PW'(PRESCALE_DIV - 1));

    // Next-state, prescaler and strobe decode; abort outranks pause,
    // pause outranks start, start outranks the tick.
    always_comb begin
        state_n    = state_q;
        presc_n    = presc_q;
        load_n     = 1'b0;
        en_n       = 1'b0;
        load_val_n = load_val_q;
        if (bus.abort) begin
            state_n = IDLE;
            presc_n = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_n    = LOAD;
                        load_n     = 1'b1;
                        load_val_n = bus.load_val;
                    end
                end
                LOAD: begin
                    state_n = RUN;
                    presc_n = '0;
                end
                RUN: begin
                    // A pause edge on a tick cycle swallows the tick; the
                    // prescaler stays at its terminal value so the tick
                    // fires on the first cycle after resume.
                    if (pause_rise) begin
                        state_n = PAUSE;
                    end else if (tick) begin
                        presc_n = '0;
                        if (bus.cnt_val != '0)
                            en_n = 1'b1;
                        else if (AUTO_RELOAD != 0)
                            load_n = 1'b1;
                        else
                            state_n = DONE;
                    end else begin
                        presc_n = presc_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (pause_rise)
                        state_n = RUN;
                end
                DONE: begin
                    if (bus.start) begin
                        state_n    = LOAD;
                        load_n     = 1'b1;
                        load_val_n = bus.load_val;
                        presc_n    = '0;
                    end
`ifdef COUNT_DOWN_DONE_BLINK_EN
                    else if (tick) begin
                        presc_n = '0;
                    end else begin
                        presc_n = presc_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_n = IDLE;
                    presc_n = '0;
                end
            endcase
        end
    end

    // Status flags follow the next state so they line up with state.
    always_comb begin
        busy_n = (state_n == LOAD) || (state_n == RUN) || (state_n == PAUSE);
`ifdef COUNT_DOWN_DONE_BLINK_EN
        if (state_n != DONE)
            done_n = 1'b0;
        else if (state_q != DONE)
            done_n = 1'b1;
        else if (tick)
            done_n = ~done_q;
        else
            done_n = done_q;
`else
        done_n = (state_n == DONE);
`endif
    end

    // State, prescaler, pause edge history and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            load_q     <= 1'b0;
            en_q       <= 1'b0;
            load_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pause_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            presc_q    <= presc_n;
            load_q     <= load_n;
            en_q       <= en_n;
            load_val_q <= load_val_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            pause_q    <= bus.pause;
        end
    end

    assign bus.cnt_load     = load_q;
    assign bus.cnt_load_val = load_val_q;
    assign bus.cnt_en       = en_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_count_down_sequencer.sv
// Bench for count_down_sequencer: two instances (stop-at-done and
// auto-reload) share key stimulus; each feeds a behavioural 4-bit counter
// and is compared every cycle against a countdown-style reference model.
module tb_count_down_sequencer;
    localparam int W   = 4;
    localparam int DIV = 4;
`ifdef COUNT_DOWN_DONE_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b1;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] cnt0 = '0;
    logic [W-1:0] cnt1 = '0;

    int checks   = 0;
    int failures = 0;
    int en_n[2];
    int ld_n[2];

    // reference model: mode uses the published state codes, m_wait counts
    // cycles left until the next tick
    int           m_mode[2];
    int           m_wait[2];
    logic [W-1:0] m_held[2];
    logic         m_load[2];
    logic         m_en[2];
    logic         m_done[2];
    logic         m_prev[2];

    count_down_sequencer_if #(.WIDTH(W)) bus0();
    count_down_sequencer_if #(.WIDTH(W)) bus1();

    assign bus0.start = start;  assign bus1.start = start;
    assign bus0.pause = pause;  assign bus1.pause = pause;
    assign bus0.abort = abort;  assign bus1.abort = abort;
    assign bus0.load_val = load_val;  assign bus1.load_val = load_val;
    assign bus0.cnt_val = cnt0;  assign bus1.cnt_val = cnt1;

    count_down_sequencer #(.WIDTH(W), .PRESCALE_DIV(DIV), .AUTO_RELOAD(0))
        dut0 (.CLOCK(CLOCK), .RESET(RESET), .bus(bus0));
    count_down_sequencer #(.WIDTH(W), .PRESCALE_DIV(DIV), .AUTO_RELOAD(1))
        dut1 (.CLOCK(CLOCK), .RESET(RESET), .bus(bus1));

    always #5 CLOCK = ~CLOCK;

    // counter datapaths driven by each sequencer's strobes
    always @(posedge CLOCK) begin
        if (bus0.cnt_load === 1'b1) cnt0 <= bus0.cnt_load_val;
        else if (bus0.cnt_en === 1'b1) cnt0 <= cnt0 - 1'b1;
        if (bus1.cnt_load === 1'b1) cnt1 <= bus1.cnt_load_val;
        else if (bus1.cnt_en === 1'b1) cnt1 <= cnt1 - 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // advance the model by one clock using the inputs about to be sampled
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic         rise;
            logic [W-1:0] c;
            rise = pause && !m_prev[i];
            c = (i == 0) ? cnt0 : cnt1;
            m_load[i] = 1'b0;
            m_en[i]   = 1'b0;
            if (RESET) begin
                m_mode[i] = 0; m_wait[i] = DIV - 1; m_held[i] = '0;
                m_done[i] = 1'b0; m_prev[i] = 1'b0;
            end else begin
                m_prev[i] = pause;
                if (abort) begin
                    m_mode[i] = 0; m_wait[i] = DIV - 1;
                end else begin
                    case (m_mode[i])
                        0, 4: begin
                            if (start) begin
                                m_mode[i] = 1; m_held[i] = load_val; m_load[i] = 1'b1;
                            end else if (m_mode[i] == 4 && BLINK) begin
                                if (m_wait[i] == 0) begin
                                    m_done[i] = !m_done[i]; m_wait[i] = DIV - 1;
                                end else m_wait[i] = m_wait[i] - 1;
                            end
                        end
                        1: begin m_mode[i] = 2; m_wait[i] = DIV - 1; end
                        2: begin
                            if (rise) m_mode[i] = 3;
                            else if (m_wait[i] == 0) begin
                                m_wait[i] = DIV - 1;
                                if (c != 0) m_en[i] = 1'b1;
                                else if (i == 1) m_load[i] = 1'b1;
                                else begin m_mode[i] = 4; m_done[i] = 1'b1; end
                            end else m_wait[i] = m_wait[i] - 1;
                        end
                        3: if (rise) m_mode[i] = 2;
                        default: ;
                    endcase
                end
                if (m_mode[i] != 4) m_done[i] = 1'b0;
            end
        end
    endtask

    task automatic cmp(input int i, input logic [2:0] st, input logic ld, input logic [W-1:0] lv,
                       input logic en, input logic bz, input logic dn);
        chk($sformatf("d%0d_state", i), st, m_mode[i]);
        chk($sformatf("d%0d_cnt_load", i), ld, m_load[i]);
        chk($sformatf("d%0d_cnt_load_val", i), lv, m_held[i]);
        chk($sformatf("d%0d_cnt_en", i), en, m_en[i]);
        chk($sformatf("d%0d_busy", i), bz, (m_mode[i] >= 1 && m_mode[i] <= 3));
        chk($sformatf("d%0d_done", i), dn, m_done[i]);
        chk($sformatf("d%0d_excl", i), ld & en, 0);
        if (en === 1'b1) en_n[i]++;
        if (ld === 1'b1) ld_n[i]++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            model_step();
            @(posedge CLOCK);
            @(negedge CLOCK);
            cmp(0, bus0.state, bus0.cnt_load, bus0.cnt_load_val, bus0.cnt_en, bus0.busy, bus0.done);
            cmp(1, bus1.state, bus1.cnt_load, bus1.cnt_load_val, bus1.cnt_en, bus1.busy, bus1.done);
        end
    endtask

    task automatic clr();
        en_n[0] = 0; en_n[1] = 0; ld_n[0] = 0; ld_n[1] = 0;
    endtask

    task automatic do_abort();
        abort = 1'b1; run(1); abort = 1'b0;
    endtask

    initial begin
        clr();
        // reset
        run(2);
        RESET = 1'b0;
        chk("rst_state", bus0.state, 0);
        chk("rst_busy", bus0.busy, 0);

        // basic countdown from 3
        load_val = 4'd3; start = 1'b1; run(1); start = 1'b0;
        chk("t1_load", bus0.cnt_load, 1);
        chk("t1_load_val", bus0.cnt_load_val, 3);
        clr(); run(17);
        chk("t1_en_pulses", en_n[0], 3);
        chk("t1_done_state", bus0.state, 4);
        chk("t1_done", bus0.done, 1);
        chk("t1_busy", bus0.busy, 0);

        // pause after two decrements, resume, finish
        do_abort();
        load_val = 4'd5; start = 1'b1; run(1); start = 1'b0;
        clr();
        for (int k = 0; k < 100 && en_n[0] < 2; k++) run(1);
        chk("t2_two_pulses", en_n[0], 2);
        pause = 1'b1; run(1); run(9);
        chk("t2_paused", bus0.state, 3);
        chk("t2_no_en_paused", en_n[0], 2);
        pause = 1'b0; run(1); pause = 1'b1; run(1);
        chk("t2_resumed", bus0.state, 2);
        pause = 1'b0;
        for (int k = 0; k < 100 && bus0.state !== 3'd4; k++) run(1);
        chk("t2_total_en", en_n[0], 5);

        // auto-reload: en, en, reload, repeating
        do_abort();
        load_val = 4'd2; clr(); start = 1'b1; run(1); start = 1'b0;
        run(39);
        chk("t3_en", en_n[1], 6);
        chk("t3_reloads", ld_n[1], 4);
        chk("t3_state", bus1.state, 2);
        chk("t3_done", bus1.done, 0);

        // abort on a tick cycle, then restart from 7
        do_abort();
        load_val = 4'd5; start = 1'b1; run(1); start = 1'b0;
        clr(); run(4);
        abort = 1'b1; run(1); abort = 1'b0;
        chk("t4_idle", bus0.state, 0);
        chk("t4_no_strobe", en_n[0], 0);
        load_val = 4'd7; start = 1'b1; run(1); start = 1'b0;
        chk("t4_reload_val", bus0.cnt_load_val, 7);
        clr(); run(20);
        chk("t4_en", en_n[0], 4);

        // pause edge coinciding with a tick
        do_abort();
        load_val = 4'd5; start = 1'b1; run(1); start = 1'b0;
        run(4);
        pause = 1'b1; run(1);
        chk("t5_paused", bus0.state, 3);
        chk("t5_no_en", bus0.cnt_en, 0);
        pause = 1'b0; run(2); pause = 1'b1; run(1); pause = 1'b0;
        chk("t5_run", bus0.state, 2);
        run(1);
        chk("t5_en_after_resume", bus0.cnt_en, 1);

        // zero start value
        do_abort();
        load_val = 4'd0; start = 1'b1; run(1); start = 1'b0;
        clr(); run(4);
        chk("t5_zero_run", bus0.state, 2);
        run(1);
        chk("t5_zero_done", bus0.state, 4);
        chk("t5_zero_en", en_n[0], 0);

`ifdef COUNT_DOWN_DONE_BLINK_EN
        // blinking done, restart from DONE
        do_abort();
        load_val = 4'd1; start = 1'b1; run(1); start = 1'b0;
        for (int k = 0; k < 50 && bus0.state !== 3'd4; k++) run(1);
        chk("t6_done_on", bus0.done, 1);
        run(4);
        chk("t6_done_off", bus0.done, 0);
        run(4);
        chk("t6_done_on2", bus0.done, 1);
        load_val = 4'd9; start = 1'b1; run(1); start = 1'b0;
        chk("t6_restart_state", bus0.state, 1);
        chk("t6_restart_done", bus0.done, 0);
        chk("t6_restart_val", bus0.cnt_load_val, 9);
`endif

        // randomized keys against the model
        for (int k = 0; k < 400; k++) begin
            start    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) pause = ~pause;
            abort    = ($urandom_range(0, 39) == 0);
            RESET    = ($urandom_range(0, 149) == 0);
            load_val = W'($urandom_range(0, 15));
            run(1);
        end
        RESET = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
